// File: rtl/seg7_pkg.sv
// Shared 7-segment constants and sizing helpers for display blocks.
package seg7_pkg;

    localparam logic [6:0] SEG7_BLANK = 7'h7F;

    localparam logic [6:0] SEG7_HEX [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    function automatic int sum_w(input int digits);
        return 4 * digits;
    endfunction

endpackage

// File: rtl/sum_seg_scanner_hex_to_seg7.sv
// Combinational nibble to active-low {g,f,e,d,c,b,a} segment decoder.
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    assign seg = SEG7_HEX[nib];

endmodule

// File: rtl/sum_seg_scanner.sv
// Registered adder/accumulator driving a multiplexed common-anode
// hex display with optional leading-zero blanking.
module sum_seg_scanner
    import seg7_pkg::*;
#(
    parameter int IN_W     = 8,
    parameter int DIGITS   = 3,
    parameter int SCAN_DIV = 50000,
    parameter int BLANK_LZ = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [IN_W-1:0]   in_0,
    input  logic [IN_W-1:0]   in_1,
    input  logic              load,
    input  logic              mode,
    input  logic              clear,
    output logic [6:0]        out_0,
    output logic [DIGITS-1:0] dig_sel,
    output logic              ovf
);

    localparam int SW = sum_w(DIGITS);
    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [SW-1:0] sum_reg;
    logic [PW-1:0] presc;
    logic [IW-1:0] scan_idx;
    logic [SW:0]   acc;
    logic [SW-1:0] add;
    logic [3:0]    nib;
    logic          hi_zero;
    logic          blank;
    logic [6:0]    seg;

    assign add = SW'(in_0) + SW'(in_1);
    assign acc = {1'b0, sum_reg} + (SW+1)'(in_0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_reg <= '0;
            ovf     <= 1'b0;
        end else if (clear) begin
            sum_reg <= '0;
            ovf     <= 1'b0;
        end else if (load) begin
            if (mode) begin
                sum_reg <= acc[SW-1:0];
                ovf     <= ovf | acc[SW];
            end else begin
                sum_reg <= add;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc    <= '0;
            scan_idx <= '0;
        end else if (presc == PW'(SCAN_DIV - 1)) begin
            presc <= '0;
            if (scan_idx == IW'(DIGITS - 1))
                scan_idx <= '0;
            else
                scan_idx <= scan_idx + 1'b1;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    // hi_zero: the selected nibble and everything above it are zero
    always_comb begin
        nib     = 4'h0;
        hi_zero = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (IW'(i) == scan_idx)
                nib = sum_reg[4*i +: 4];
            if (IW'(i) >= scan_idx && sum_reg[4*i +: 4] != 4'h0)
                hi_zero = 1'b0;
        end
    end

    assign blank = (BLANK_LZ != 0) && (scan_idx != '0) && hi_zero;

    hex_to_seg7 u_dec (
        .nib (nib),
        .seg (seg)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_0   <= SEG7_BLANK;
            dig_sel <= '1;
        end else begin
            out_0   <= blank ? SEG7_BLANK : seg;
            dig_sel <= ~(DIGITS'(1) << scan_idx);
        end
    end

endmodule
